// File: rtl/demux4_dispatcher.sv
// 1-to-4 byte dispatcher: one valid/ready input fanned out to four 1-entry output registers,
// steered either by a per-byte tag or by a round-robin pointer that skips occupied channels.
module demux4_dispatcher #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic             A_valid,
   output logic             A_ready,
   input  logic [1:0]       S,
   input  logic             mode,
   output logic [WIDTH-1:0] Out1,
   output logic [WIDTH-1:0] Out2,
   output logic [WIDTH-1:0] Out3,
   output logic [WIDTH-1:0] Out4,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [1:0]       last_dest,
   output logic             drop_busy
);

   logic [WIDTH-1:0] out_q [4];
   logic [3:0]       out_valid_q;
   logic [1:0]       ptr_q;
   logic [1:0]       last_dest_q;

   logic [3:0] free;
   logic [1:0] rr_target;
   logic       rr_found;
   logic [1:0] target;
   logic       accept;

   // A channel drained this cycle can be refilled in the same cycle.
   assign free = ~out_valid_q | out_ready;

   always_comb begin
      rr_target = ptr_q;
      rr_found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!rr_found && free[ptr_q + 2'(i)]) begin
            rr_target = ptr_q + 2'(i);
            rr_found  = 1'b1;
         end
      end
   end

   always_comb begin
      target  = mode ? rr_target : S;
      A_ready = mode ? rr_found : free[S];
   end

   assign accept    = A_valid && A_ready;
   assign drop_busy = A_valid && !A_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) out_q[k] <= '0;
         out_valid_q <= '0;
         ptr_q       <= '0;
         last_dest_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid_q[k] && out_ready[k]) out_valid_q[k] <= 1'b0;
         end
         // Later assignment wins, so a refill overrides the drain-clear above.
         if (accept) begin
            out_q[target]       <= A;
            out_valid_q[target] <= 1'b1;
            last_dest_q         <= target;
            if (mode) ptr_q <= target + 2'd1;
         end
      end
   end

   assign Out1      = out_q[0];
   assign Out2      = out_q[1];
   assign Out3      = out_q[2];
   assign Out4      = out_q[3];
   assign out_valid = out_valid_q;
   assign last_dest = last_dest_q;

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Directed self-checking bench for demux4_dispatcher: inputs change 1ns after the rising edge,
// combinational outputs are checked at the falling edge, registered ones 1ns after the rising edge.
module tb_demux4_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] A;
   logic       A_valid;
   logic       A_ready;
   logic [1:0] S;
   logic       mode;
   logic [7:0] Out1, Out2, Out3, Out4;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [1:0] last_dest;
   logic       drop_busy;

   logic [7:0] outs [4];
   int errors = 0;
   int checks = 0;

   assign outs[0] = Out1;
   assign outs[1] = Out2;
   assign outs[2] = Out3;
   assign outs[3] = Out4;

   always #5 clk = ~clk;

   demux4_dispatcher #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .A_valid   (A_valid),
      .A_ready   (A_ready),
      .S         (S),
      .mode      (mode),
      .Out1      (Out1),
      .Out2      (Out2),
      .Out3      (Out3),
      .Out4      (Out4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .last_dest (last_dest),
      .drop_busy (drop_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; A = 8'h00; A_valid = 1'b0; S = 2'b00; mode = 1'b0; out_ready = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (outs[k] !== 8'h00) begin
            errors++; $display("FAIL reset_out%0d got=%h exp=00", k + 1, outs[k]);
         end
      end
      checks++;
      if (last_dest !== 2'b00) begin
         errors++; $display("FAIL reset_last_dest got=%b exp=00", last_dest);
      end
      checks++;
      if (A_ready !== 1'b1 || drop_busy !== 1'b0) begin
         errors++; $display("FAIL reset_ready got A_ready=%b drop_busy=%b exp 1/0", A_ready, drop_busy);
      end
   endtask

   task automatic test_directed();
      logic [7:0] bytes [4];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      tick();
      mode = 1'b0; out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         A = bytes[i]; S = 2'(i); A_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (A_ready !== 1'b1) begin
            errors++; $display("FAIL dir_ready%0d got=%b exp=1", i, A_ready);
         end
         tick();
         checks++;
         if (out_valid !== (4'b0001 << i) || outs[i] !== bytes[i] || last_dest !== 2'(i)) begin
            errors++;
            $display("FAIL dir_out%0d got valid=%b data=%h last=%0d exp valid=%b data=%h last=%0d",
                     i, out_valid, outs[i], last_dest, 4'b0001 << i, bytes[i], i);
         end
      end
      A_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++; $display("FAIL dir_drained got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_backpressure();
      mode = 1'b0; out_ready = 4'b1110; S = 2'b00; A = 8'h5A; A_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (A_ready !== 1'b1) begin
         errors++; $display("FAIL bp_first_ready got=%b exp=1", A_ready);
      end
      tick();
      A = 8'hA5;
      @(negedge clk);
      checks++;
      if (A_ready !== 1'b0 || drop_busy !== 1'b1) begin
         errors++; $display("FAIL bp_stall got A_ready=%b drop_busy=%b exp 0/1", A_ready, drop_busy);
      end
      tick();
      checks++;
      if (Out1 !== 8'h5A || out_valid !== 4'b0001) begin
         errors++; $display("FAIL bp_hold got Out1=%h valid=%b exp 5a/0001", Out1, out_valid);
      end
      out_ready = 4'b1111;
      @(negedge clk);
      checks++;
      if (A_ready !== 1'b1 || drop_busy !== 1'b0) begin
         errors++; $display("FAIL bp_release got A_ready=%b drop_busy=%b exp 1/0", A_ready, drop_busy);
      end
      tick();
      checks++;
      if (Out1 !== 8'hA5 || out_valid !== 4'b0001) begin
         errors++; $display("FAIL bp_replace got Out1=%h valid=%b exp a5/0001", Out1, out_valid);
      end
      A_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++; $display("FAIL bp_drained got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_rr_order();
      logic [1:0] exp_dest [6];
      exp_dest[0] = 2'd0; exp_dest[1] = 2'd1; exp_dest[2] = 2'd2;
      exp_dest[3] = 2'd3; exp_dest[4] = 2'd0; exp_dest[5] = 2'd1;
      mode = 1'b1; out_ready = 4'b1111; A_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         A = 8'(i + 1);
         tick();
         checks++;
         if (out_valid !== (4'b0001 << exp_dest[i]) || outs[exp_dest[i]] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL rr_order%0d got valid=%b data=%h exp valid=%b data=%h",
                     i, out_valid, outs[exp_dest[i]], 4'b0001 << exp_dest[i], 8'(i + 1));
         end
      end
      checks++;
      if (last_dest !== 2'b01) begin
         errors++; $display("FAIL rr_last_dest got=%b exp=01", last_dest);
      end
      A_valid = 1'b0;
      tick();
   endtask

   task automatic test_rr_skip();
      // ptr is 2 here; park BB in Out2 with its consumer stalled, then walk ptr to 1.
      mode = 1'b0; out_ready = 4'b1101; S = 2'b01; A = 8'hBB; A_valid = 1'b1;
      tick();
      mode = 1'b1;
      A = 8'hC1; tick();
      A = 8'hC2; tick();
      A = 8'hC3; tick();
      checks++;
      if (Out1 !== 8'hC3 || last_dest !== 2'd0) begin
         errors++; $display("FAIL skip_setup got Out1=%h last=%0d exp c3/0", Out1, last_dest);
      end
      A = 8'h77;
      tick();
      checks++;
      if (Out3 !== 8'h77 || last_dest !== 2'd2 || out_valid !== 4'b0110 || Out2 !== 8'hBB) begin
         errors++;
         $display("FAIL skip_target got Out3=%h last=%0d valid=%b Out2=%h exp 77/2/0110/bb",
                  Out3, last_dest, out_valid, Out2);
      end
      A = 8'h88;
      tick();
      checks++;
      if (Out4 !== 8'h88 || last_dest !== 2'd3 || out_valid !== 4'b1010) begin
         errors++;
         $display("FAIL skip_ptr got Out4=%h last=%0d valid=%b exp 88/3/1010",
                  Out4, last_dest, out_valid);
      end
      A_valid = 1'b0; out_ready = 4'b1111;
      tick();
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++; $display("FAIL skip_drained got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_full_reset();
      mode = 1'b1; out_ready = 4'b0000; A_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         A = 8'hD0 + 8'(i);
         tick();
      end
      checks++;
      if (out_valid !== 4'b1111 || Out1 !== 8'hD0 || Out2 !== 8'hD1 || Out3 !== 8'hD2 ||
          Out4 !== 8'hD3) begin
         errors++;
         $display("FAIL full_fill got valid=%b outs=%h %h %h %h exp 1111 d0 d1 d2 d3",
                  out_valid, Out1, Out2, Out3, Out4);
      end
      A = 8'hEE;
      @(negedge clk);
      checks++;
      if (A_ready !== 1'b0 || drop_busy !== 1'b1) begin
         errors++; $display("FAIL full_stall got A_ready=%b drop_busy=%b exp 0/1", A_ready, drop_busy);
      end
      tick();
      checks++;
      if (out_valid !== 4'b1111 || Out1 !== 8'hD0) begin
         errors++; $display("FAIL full_hold got valid=%b Out1=%h exp 1111/d0", out_valid, Out1);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (out_valid !== 4'b0000 || Out1 !== 8'h00 || Out4 !== 8'h00 || last_dest !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset got valid=%b Out1=%h Out4=%h last=%0d exp 0000/00/00/0",
                  out_valid, Out1, Out4, last_dest);
      end
      rst = 1'b0; A_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (A_ready !== 1'b1 || drop_busy !== 1'b0) begin
         errors++; $display("FAIL post_reset got A_ready=%b drop_busy=%b exp 1/0", A_ready, drop_busy);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_rr_order();
      test_rr_skip();
      test_full_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux4_dispatcher.md
# demux4_dispatcher

Sequencing controller that wraps the 8-bit 1-to-4 demultiplexer datapath. It accepts a byte stream on a single valid/ready input and delivers each byte to one of four output channels. Each channel has a 1-entry output register with its own valid/ready handshake. The destination comes either from a per-byte tag (directed mode) or from an internal round-robin scheduler that skips channels whose register is occupied.

## Interface
- WIDTH, 8, data width of input and of each output channel
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous reset, active-high
- A  input  WIDTH  input data byte
- A_valid  input  1  input byte present
- A_ready  output  1  dispatcher accepts A this cycle (combinational)
- S  input  2  destination tag: 00→Out1, 01→Out2, 10→Out3, 11→Out4; used only when mode=0
- mode  input  1  0 = directed by S, 1 = round-robin
- Out1..Out4  output  WIDTH each  channel data registers
- out_valid  output  4  bit k-1 = Out k holds an undelivered byte
- out_ready  input  4  bit k-1 = consumer of Out k takes the byte this cycle
- last_dest  output  2  channel index of the most recent accepted byte
- drop_busy  output  1  A_valid high and A_ready low this cycle (stall indicator)

## Operation
- Transfer on input when A_valid && A_ready. Transfer on channel k when out_valid[k] && out_ready[k].
- Channel k is free when !out_valid[k] || out_ready[k]. A drain and a refill in the same cycle are allowed.
- Directed mode (mode=0):
  - target = S.
  - A_ready = free[S].
- Round-robin mode (mode=1):
  - Pointer ptr[1:0] is held in a register.
  - target = first free channel scanning ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - A_ready = any free channel.
  - On accept, ptr ← target+1 (mod 4; 3 wraps to 0).
  - ptr does not move in directed mode or without an accept.
- On accept:
  - Out[target] ← A and out_valid[target] ← 1.
  - last_dest ← target.
  - All other channel registers hold.
- On drain of channel k without a refill of k: out_valid[k] ← 0. Out k keeps its stale data.
- Changing mode takes effect on the same cycle's target computation. ptr is not reset by a mode change.
- A_ready must not depend on A_valid. out_valid must not depend on out_ready.
- Reset values:
  - out_valid=0000, Out1..Out4=0, ptr=0, last_dest=00.
  - After reset: drop_busy=0 and A_ready=1 (all channels free).
- Reset mid-operation discards all buffered bytes without handshake. Consumers must ignore the cycle in which rst is high.

## Timing
- Latency: a byte accepted at edge n is visible on Out[target] with out_valid set after edge n. That is one cycle, registered.
- Throughput: one byte per cycle sustained when the consumers keep out_ready high.
- In round-robin mode with all consumers ready, the dispatch order is 0,1,2,3,0,…
- Ordering per channel is preserved trivially because each channel holds 1 entry.
- Simultaneous accept into k and drain of k: the new byte replaces the old and out_valid stays 1.
- A channel whose consumer is stalled stalls directed traffic to that channel only. Round-robin traffic flows around the stalled channel.
- All four full with out_ready=0000: A_ready=0 and drop_busy = A_valid.

## Test plan
- Reset then idle:
  - Pulse rst for 2 cycles.
  - Required: out_valid=0000, Out1..4=00, last_dest=00, A_ready=1.
- Directed dispatch:
  - mode=0, out_ready=1111; send A=11,22,33,44 with S=00,01,10,11 on 4 back-to-back cycles.
  - Required: each OutK carries its byte exactly 1 cycle after acceptance, with one-hot out_valid.
- Directed backpressure:
  - mode=0, out_ready=1110; send A=5A with S=00, then A=A5 with S=00.
  - Required: the first byte is accepted. The second sees A_ready=0 and drop_busy=1.
  - Required: raising out_ready[0] drains 5A and accepts A5 in the same cycle, with out_valid[0] staying 1.
- Round-robin order and wrap:
  - mode=1, out_ready=1111; send 6 bytes 01..06.
  - Required: destinations 0,1,2,3,0,1 and last_dest=01 at the end.
- Round-robin skip:
  - mode=1, ptr=1, out_ready[1]=0 with Out2 already full; send A=77.
  - Required: 77 goes to Out3, ptr becomes 3, and Out2 is unchanged.
- All full and reset mid-operation:
  - Fill all 4 with out_ready=0000, hold A_valid=1.
  - Required: A_ready=0 and drop_busy=1.
  - Assert rst: out_valid=0000 on the next cycle and no output handshake occurs.
